// File: rtl/one_wire_rx_ctrl.sv
// rtl/one_wire_rx_ctrl.sv - 1-wire master: bus reset, presence detect, command byte out, read bytes into a buffer
// All bus intervals are counted in clk cycles derived from CLK_PER_US.
module one_wire_rx_ctrl #(
    parameter int CLK_PER_US = 50,
    parameter int MAX_BYTES  = 32
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_cmd_byte,
    input  logic [5:0] i_rd_count,
    input  logic       i_ow_in,
    output logic       o_ow_drive_low,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_no_presence,
    output logic       o_write,
    output logic [4:0] o_write_address,
    output logic [7:0] o_data_in
);

    localparam int CW = $clog2(480 * CLK_PER_US + 1);

    // Terminal counts are the last cycle of each interval; low lengths are cycle counts.
    localparam logic [CW-1:0] T_RST  = CW'(480 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_PRES = CW'(70 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_REST = CW'(410 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_SLOT = CW'(70 * CLK_PER_US - 1);
    localparam logic [CW-1:0] T_LOW1 = CW'(6 * CLK_PER_US);
    localparam logic [CW-1:0] T_LOW0 = CW'(60 * CLK_PER_US);
    localparam logic [CW-1:0] T_SAMP = CW'(15 * CLK_PER_US);
    localparam logic [5:0]    MAX_CNT = 6'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_PRES_WAIT,
        S_PRES_REST,
        S_TX_SLOT,
        S_RX_SLOT,
        S_STORE,
        S_FINISH
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_cmd;
    logic [7:0]    r_shift;
    logic [5:0]    r_rd_count;
    logic [5:0]    r_byte_idx;
    logic          r_sync1;
    logic          r_sync2;

    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_tx_low;
    logic [5:0]    w_idx_nxt;

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_tx_low  = r_cmd[0] ? T_LOW1 : T_LOW0;
    assign w_idx_nxt = r_byte_idx + 6'd1;

    // Idle bus level is high, so the synchronizer resets to 1.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_ow_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_bit           <= '0;
            r_cmd           <= '0;
            r_shift         <= '0;
            r_rd_count      <= '0;
            r_byte_idx      <= '0;
            o_ow_drive_low  <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_no_presence   <= 1'b0;
            o_write         <= 1'b0;
            o_write_address <= '0;
            o_data_in       <= '0;
        end else begin
            o_write <= 1'b0;
            o_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cmd          <= i_cmd_byte;
                        r_rd_count     <= (i_rd_count > MAX_CNT) ? MAX_CNT : i_rd_count;
                        o_no_presence  <= 1'b0;
                        o_busy         <= 1'b1;
                        r_cnt          <= '0;
                        o_ow_drive_low <= 1'b1;
                        r_state        <= S_RST_LOW;
                    end
                end
                S_RST_LOW: begin
                    if (r_cnt == T_RST) begin
                        r_cnt          <= '0;
                        o_ow_drive_low <= 1'b0;
                        r_state        <= S_PRES_WAIT;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_PRES_WAIT: begin
                    if (r_cnt == T_PRES) begin
                        r_cnt <= '0;
                        if (r_sync2) begin
                            o_no_presence <= 1'b1;
                            o_done        <= 1'b1;
                            o_busy        <= 1'b0;
                            r_state       <= S_FINISH;
                        end else begin
                            r_state <= S_PRES_REST;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_PRES_REST: begin
                    if (r_cnt == T_REST) begin
                        r_cnt          <= '0;
                        r_bit          <= '0;
                        o_ow_drive_low <= 1'b1;
                        r_state        <= S_TX_SLOT;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_TX_SLOT: begin
                    // The drive level is registered, so it is decided for the count being entered.
                    if (r_cnt == T_SLOT) begin
                        r_cnt <= '0;
                        r_cmd <= {1'b0, r_cmd[7:1]};
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            if (r_rd_count == 6'd0) begin
                                o_ow_drive_low <= 1'b0;
                                o_done         <= 1'b1;
                                o_busy         <= 1'b0;
                                r_state        <= S_FINISH;
                            end else begin
                                r_byte_idx     <= '0;
                                o_ow_drive_low <= 1'b1;
                                r_state        <= S_RX_SLOT;
                            end
                        end else begin
                            o_ow_drive_low <= 1'b1;
                        end
                    end else begin
                        r_cnt          <= w_cnt_nxt;
                        o_ow_drive_low <= (w_cnt_nxt < w_tx_low);
                    end
                end
                S_RX_SLOT: begin
                    if (r_cnt == T_SLOT) begin
                        r_cnt <= '0;
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            o_write         <= 1'b1;
                            o_write_address <= r_byte_idx[4:0];
                            o_data_in       <= r_shift;
                            o_ow_drive_low  <= 1'b0;
                            r_state         <= S_STORE;
                        end else begin
                            o_ow_drive_low <= 1'b1;
                        end
                    end else begin
                        r_cnt          <= w_cnt_nxt;
                        o_ow_drive_low <= (w_cnt_nxt < T_LOW1);
                        if (r_cnt == T_SAMP) begin
                            r_shift <= {r_sync2, r_shift[7:1]};
                        end
                    end
                end
                S_STORE: begin
                    r_byte_idx <= w_idx_nxt;
                    if (w_idx_nxt == r_rd_count) begin
                        o_ow_drive_low <= 1'b0;
                        o_done         <= 1'b1;
                        o_busy         <= 1'b0;
                        r_state        <= S_FINISH;
                    end else begin
                        o_ow_drive_low <= 1'b1;
                        r_state        <= S_RX_SLOT;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    o_ow_drive_low <= 1'b0;
                    o_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_one_wire_rx_ctrl.sv
// tb/tb_one_wire_rx_ctrl.sv - directed bench for one_wire_rx_ctrl with a behavioural 1-wire device
module tb_one_wire_rx_ctrl;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cmd   = 8'h00;
    logic [5:0] rdc   = 6'd0;
    logic       ow_in;
    logic       drv;
    logic       busy;
    logic       done;
    logic       no_pres;
    logic       wr;
    logic [4:0] waddr;
    logic [7:0] wdata;

    logic        dev_en  = 1'b1;
    logic [15:0] dev_pat = 16'hFF28;
    logic        dev_pull;

    int checks = 0;
    int errors = 0;

    one_wire_rx_ctrl #(.CLK_PER_US(2), .MAX_BYTES(32)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_start         (start),
        .i_cmd_byte      (cmd),
        .i_rd_count      (rdc),
        .i_ow_in         (ow_in),
        .o_ow_drive_low  (drv),
        .o_busy          (busy),
        .o_done          (done),
        .o_no_presence   (no_pres),
        .o_write         (wr),
        .o_write_address (waddr),
        .o_data_in       (wdata)
    );

    always #5 clk = ~clk;

    // Device: presence pulse after a long low, then answers read slots from dev_pat.
    logic prev_drv   = 1'b0;
    int   low_run    = 0;
    int   pres_cnt   = 0;
    int   hold       = 0;
    int   slot_n     = 0;
    int   rst_len    = 0;
    int   rst_pulses = 0;
    int   slot_len_q[$];

    assign dev_pull = (hold > 0) || (pres_cnt >= 30 && pres_cnt < 270);
    assign ow_in    = !(drv === 1'b1 || dev_pull);

    always @(posedge clk) begin
        prev_drv <= (drv === 1'b1);
        if (drv === 1'b1) low_run <= prev_drv ? low_run + 1 : 1;
        if (drv !== 1'b1 && prev_drv) begin
            if (low_run >= 400) begin
                rst_len    <= low_run;
                rst_pulses <= rst_pulses + 1;
                slot_n     <= 0;
                pres_cnt   <= dev_en ? 1 : 0;
            end else begin
                slot_len_q.push_back(low_run);
                slot_n <= slot_n + 1;
            end
        end else if (pres_cnt > 0) begin
            pres_cnt <= (pres_cnt >= 270) ? 0 : pres_cnt + 1;
        end
        if (drv === 1'b1 && !prev_drv && dev_en && slot_n >= 8 && !dev_pat[(slot_n - 8) % 16])
            hold <= 60;
        else if (hold > 0)
            hold <= hold - 1;
    end

    logic [4:0] wa_q[$];
    logic [7:0] wd_q[$];
    int         done_cnt = 0;

    always @(posedge clk) begin
        if (wr === 1'b1) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] c, input logic [5:0] r);
        cmd   = c;
        rdc   = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(n < limit), 32'd1);
    endtask

    function automatic logic [7:0] tx_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            if (base + i >= slot_len_q.size()) b[i] = 1'bx;
            else if (slot_len_q[base + i] == 12) b[i] = 1'b1;
            else if (slot_len_q[base + i] == 120) b[i] = 1'b0;
            else b[i] = 1'bx;
        end
        return b;
    endfunction

    function automatic logic [12:0] wr_at(input int i);
        if (i >= wa_q.size()) return 'x;
        return {wa_q[i], wd_q[i]};
    endfunction

    int n;
    int b_w, b_s, b_d, b_r;

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_async_drive", drv, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_outs", {done, no_pres, wr, waddr, wdata}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_drive", drv, 0);
        check("idle_busy", busy, 0);

        // Normal read: command 0xCC, two bytes 0x28, 0xFF.
        b_w = wa_q.size(); b_s = slot_len_q.size(); b_d = done_cnt; b_r = rst_pulses;
        do_start(8'hCC, 6'd2);
        check("t1_busy", busy, 1);
        check("t1_drive_reset", drv, 1);
        wait_done("t1_done_timeout", 8000, n);
        check("t1_busy_at_done", busy, 0);
        check("t1_no_presence", no_pres, 0);
        @(posedge clk); #1;
        check("t1_reset_len", rst_len, 960);
        check("t1_reset_pulses", rst_pulses - b_r, 1);
        check("t1_slots", slot_len_q.size() - b_s, 24);
        check("t1_cmd_bits", tx_byte(b_s), 8'hCC);
        check("t1_writes", wa_q.size() - b_w, 2);
        check("t1_wr0", wr_at(b_w), {5'd0, 8'h28});
        check("t1_wr1", wr_at(b_w + 1), {5'd1, 8'hFF});
        check("t1_done_count", done_cnt - b_d, 1);

        // No device on the bus.
        dev_en = 1'b0;
        b_w = wa_q.size(); b_s = slot_len_q.size();
        do_start(8'hCC, 6'd2);
        wait_done("t2_done_timeout", 3000, n);
        check("t2_done_latency_ok", 32'(n >= 1099 && n <= 1101), 32'd1);
        check("t2_no_presence", no_pres, 1);
        repeat (50) @(posedge clk);
        #1;
        check("t2_no_presence_held", no_pres, 1);
        check("t2_writes", wa_q.size() - b_w, 0);
        check("t2_slots", slot_len_q.size() - b_s, 0);
        check("t2_drive", drv, 0);
        dev_en = 1'b1;

        // Command only: 0x44, zero read bytes.
        b_w = wa_q.size(); b_s = slot_len_q.size();
        do_start(8'h44, 6'd0);
        check("t3_no_presence_cleared", no_pres, 0);
        wait_done("t3_done_timeout", 5000, n);
        @(posedge clk); #1;
        check("t3_slots", slot_len_q.size() - b_s, 8);
        check("t3_cmd_bits", tx_byte(b_s), 8'h44);
        check("t3_writes", wa_q.size() - b_w, 0);

        // Read count above buffer depth is clamped.
        b_w = wa_q.size(); b_d = done_cnt;
        do_start(8'hCC, 6'd40);
        wait_done("t4_done_timeout", 45000, n);
        @(posedge clk); #1;
        check("t4_writes", wa_q.size() - b_w, 32);
        for (int i = 0; i < 32; i++)
            check($sformatf("t4_wr%0d", i), wr_at(b_w + i), {5'(i), (i % 2 == 0) ? 8'h28 : 8'hFF});
        check("t4_done_count", done_cnt - b_d, 1);

        // Reset in the middle of read byte 3.
        b_w = wa_q.size(); b_d = done_cnt;
        do_start(8'hCC, 6'd5);
        n = 0;
        while (wa_q.size() < b_w + 3 && n < 8000) begin @(posedge clk); #1; n++; end
        check("t5_reach_byte3", 32'(n < 8000), 32'd1);
        n = 0;
        while (drv !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        check("t5_slot_low", drv, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_drive_async", drv, 0);
        check("t5_busy_async", busy, 0);
        check("t5_outs_async", {done, wr, waddr, wdata}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2000) @(posedge clk);
        #1;
        check("t5_writes_after_abort", wa_q.size() - b_w, 3);
        check("t5_no_done", done_cnt - b_d, 0);
        check("t5_idle_busy", busy, 0);
        b_w = wa_q.size(); b_d = done_cnt;
        do_start(8'hCC, 6'd2);
        wait_done("t5b_done_timeout", 8000, n);
        @(posedge clk); #1;
        check("t5b_writes", wa_q.size() - b_w, 2);
        check("t5b_wr0", wr_at(b_w), {5'd0, 8'h28});
        check("t5b_wr1", wr_at(b_w + 1), {5'd1, 8'hFF});
        check("t5b_no_presence", no_pres, 0);

        // A second start while busy must be ignored.
        b_w = wa_q.size(); b_s = slot_len_q.size(); b_d = done_cnt;
        do_start(8'hCC, 6'd1);
        repeat (200) @(posedge clk);
        #1;
        do_start(8'h00, 6'd3);
        wait_done("t6_done_timeout", 6000, n);
        repeat (3000) @(posedge clk);
        #1;
        check("t6_done_count", done_cnt - b_d, 1);
        check("t6_writes", wa_q.size() - b_w, 1);
        check("t6_wr0", wr_at(b_w), {5'd0, 8'h28});
        check("t6_cmd_bits", tx_byte(b_s), 8'hCC);
        check("t6_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/one_wire_rx_ctrl.md
ONE_WIRE_RX_CTRL -- requirements
Module: one_wire_rx_ctrl

Interface
REQ-001 Parameter CLK_PER_US, default 50: clk cycles per microsecond; all bus timing derives from it.
REQ-002 Parameter MAX_BYTES, default 32: buffer depth; write_address width is 5.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to run a transaction; sampled only in IDLE.
REQ-006 cmd_byte  input  8  command transmitted after presence; captured on accepted start.
REQ-007 rd_count  input  6  bytes to read after the command; captured on accepted start.
REQ-008 ow_in  input  1  raw 1-wire bus level.
REQ-009 ow_drive_low  output  1  1 = pull bus low (open-drain enable); 0 = release.
REQ-010 busy  output  1  high from accepted start until done.
REQ-011 done  output  1  one-cycle pulse at transaction end.
REQ-012 no_presence  output  1  result flag: no device answered the last reset; valid from done until the next accepted start.
REQ-013 write  output  1  one-cycle buffer write strobe.
REQ-014 write_address  output  5  buffer address for write.
REQ-015 data_in  output  8  received byte, valid while write=1.

Function
REQ-016 ow_in passes through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-017 States: IDLE, RST_LOW, PRES_WAIT, PRES_REST, TX_SLOT, RX_SLOT, STORE, FINISH.
REQ-018 IDLE: start=1 -> capture cmd_byte, rd_count (clamped to MAX_BYTES if larger), clear no_presence, busy=1 -> RST_LOW.
REQ-019 RST_LOW: ow_drive_low=1 for 480 us -> PRES_WAIT.
REQ-020 PRES_WAIT: bus released for 70 us; sample at last cycle; sampled 0 = presence -> PRES_REST; sampled 1 -> no_presence=1 -> FINISH.
REQ-021 PRES_REST: released 410 us -> TX_SLOT.
REQ-022 TX_SLOT: 8 slots, cmd_byte LSB first, 70 us each; bit 1 = low 6 us then release 64 us; bit 0 = low 60 us then release 10 us.
REQ-023 After 8th TX slot: rd_count=0 -> FINISH; else RX_SLOT with byte index 0.
REQ-024 RX_SLOT: 8 slots, 70 us each: low 6 us, release, sample at 15 us from slot start; bits shift in LSB first.
REQ-025 STORE (one cycle): write=1, write_address=byte index, data_in=assembled byte; index increments; index = rd_count -> FINISH, else RX_SLOT.
REQ-026 FINISH (one cycle): done=1, busy=0 -> IDLE.
REQ-027 Bytes written to addresses 0..rd_count-1 in order, exactly one write per byte, no other writes.
REQ-028 start while busy is ignored; captured parameters cannot change mid-transaction.
REQ-029 ow_drive_low is 0 in IDLE, FINISH, STORE, and all release intervals.
REQ-030 Timing counter wide enough for 480*CLK_PER_US; interval durations exact to +/-1 cycle.

Reset
REQ-031 On reset assertion, immediately and asynchronously: state=IDLE, ow_drive_low=0, busy=0, done=0, write=0, no_presence=0, write_address=0, data_in=0, counters and shift register cleared.
REQ-032 Reset mid-transaction aborts with no further write strobes; first start after reset release begins a fresh transaction.

Verification (CLK_PER_US=2)
REQ-033 Device model answers presence, returns 0x28,0xFF; start, cmd_byte=0xCC, rd_count=2 -> reset low 960 cycles, command slots LSB first, writes (0,0x28),(1,0xFF), done, no_presence=0.
REQ-034 No device (ow_in held 1), start -> no_presence=1, done after RST_LOW+PRES_WAIT, zero writes, no TX slots driven.
REQ-035 rd_count=0, cmd_byte=0x44 -> 8 TX slots with pattern 0,0,1,0,0,0,1,0, then done, zero writes.
REQ-036 rd_count=40 -> exactly 32 writes to addresses 0..31, then done.
REQ-037 Reset asserted during RX_SLOT byte 3 -> ow_drive_low=0 same cycle, no further writes, busy=0; new start completes normally.
REQ-038 Second start pulse during busy -> ignored; single done, write count unchanged.
